// File: rtl/demux_pkg.sv
// Shared constants and helpers for the stream demultiplexer.
package demux_pkg;

  localparam int unsigned DEMUX_MAX_CH = 64;

  function automatic logic sel_in_range(input int unsigned sel, input int unsigned num_ch);
    return (sel < num_ch);
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One output channel: single-entry register, valid bit and saturating delivery counter.
module demux_slot #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [CNT_WIDTH-1:0]  cnt_o,
  output logic                  free_o
);

  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  assign free_o  = ~valid_q | ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign cnt_o   = cnt_q;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      // A load in the same cycle as a drain keeps the slot full.
      if (load_i) begin
        valid_q <= 1'b1;
        data_q  <= data_i;
      end else if (ready_i) begin
        valid_q <= 1'b0;
      end
      if (valid_q && ready_i && (cnt_q != {CNT_WIDTH{1'b1}})) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_stream.sv
// 1-to-NUM_CH valid/ready stream demultiplexer with unicast and broadcast steering.
module demux_stream
  import demux_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_CH     = 8,
  parameter int unsigned CNT_WIDTH  = 16,
  localparam int unsigned SEL_WIDTH = $clog2(NUM_CH)
) (
  input  logic                           clk_i,
  input  logic                           arst_i,
  input  logic [SEL_WIDTH-1:0]           sel_i,
  input  logic                           bcast_i,
  input  logic                           in_valid_i,
  input  logic [DATA_WIDTH-1:0]          in_data_i,
  output logic                           in_ready_o,
  output logic [NUM_CH-1:0]              out_valid_o,
  output logic [NUM_CH*DATA_WIDTH-1:0]   out_data_o,
  input  logic [NUM_CH-1:0]              out_ready_i,
  output logic                           err_sel_o,
  output logic [NUM_CH*CNT_WIDTH-1:0]    xfer_cnt_o
);

  logic [NUM_CH-1:0] slot_free;
  logic [NUM_CH-1:0] slot_load;
  logic              sel_ok;
  logic              sel_free;
  logic              accept;
  logic              err_q;

  always_comb begin
    sel_ok   = sel_in_range(32'(sel_i), NUM_CH);
    sel_free = 1'b0;
    // Loop decode avoids indexing past NUM_CH when NUM_CH is not a power of 2.
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (32'(sel_i) == k) sel_free = slot_free[k];
    end
    if (bcast_i) begin
      in_ready_o = &slot_free;
    end else if (sel_ok) begin
      in_ready_o = sel_free;
    end else begin
      in_ready_o = 1'b1;
    end
    accept = in_valid_i & in_ready_o;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      slot_load[k] = accept & (bcast_i | (32'(sel_i) == k));
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= accept & ~bcast_i & ~sel_ok;
    end
  end

  assign err_sel_o = err_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    demux_slot #(
      .DATA_WIDTH(DATA_WIDTH),
      .CNT_WIDTH (CNT_WIDTH)
    ) u_slot (
      .clk_i  (clk_i),
      .arst_i (arst_i),
      .load_i (slot_load[k]),
      .data_i (in_data_i),
      .ready_i(out_ready_i[k]),
      .valid_o(out_valid_o[k]),
      .data_o (out_data_o[k*DATA_WIDTH +: DATA_WIDTH]),
      .cnt_o  (xfer_cnt_o[k*CNT_WIDTH +: CNT_WIDTH]),
      .free_o (slot_free[k])
    );
  end

endmodule
